// File: rtl/shift_pkg.sv
// shift_pkg: shared state encoding and counter sizing for the shift engine.
package shift_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} stateT;
    function automatic int CNT_W(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/shift_engine_bit_counter.sv
// bit_counter: frame bit counter with clear, enable and a terminal flag at WIDTH.
module bit_counter import shift_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    enable,
    output logic [CNT_W(WIDTH)-1:0] count,
    output logic                    terminal
);
    localparam int CW = CNT_W(WIDTH);
    assign terminal = count == CW'(WIDTH);
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (enable) count <= count + 1'b1;
endmodule

// File: rtl/shift_engine.sv
// shift_engine: handshaked serial/parallel shifter advanced by a peripheral-edge clock enable.
module shift_engine import shift_pkg::*; #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    peripheralClkEdge,
    input  logic                    loadValid,
    output logic                    loadReady,
    input  logic [WIDTH-1:0]        loadData,
    input  logic                    lsbFirst,
    input  logic                    abort,
    input  logic                    serialDataIn,
    output logic                    serialDataOut,
    output logic [WIDTH-1:0]        parallelDataOut,
    output logic                    frameValid,
    output logic                    busy,
    output logic [CNT_W(WIDTH)-1:0] bitCount
);
    localparam int CW = CNT_W(WIDTH);
    stateT state;
    logic [WIDTH-1:0] shiftReg;
    logic lsbLatched, terminal, loadFire, abortFire, shiftFire, lastShift;
    assign loadReady = state == IDLE;
    assign busy = state == SHIFT;
    assign loadFire = loadValid & loadReady;
    assign abortFire = busy & abort;
    // abort outranks a coincident strobe, including the frame-ending one
    assign shiftFire = busy & peripheralClkEdge & ~abort & ~terminal;
    assign lastShift = shiftFire & (bitCount == CW'(WIDTH - 1));
    assign serialDataOut = lsbLatched ? shiftReg[0] : shiftReg[WIDTH-1];
    assign parallelDataOut = shiftReg;
    bit_counter #(.WIDTH(WIDTH)) counter (
        .clk(clk),
        .reset(reset),
        .clear(loadFire | abortFire),
        .enable(shiftFire),
        .count(bitCount),
        .terminal(terminal)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            shiftReg <= RESET_VALUE;
            lsbLatched <= 1'b0;
            frameValid <= 1'b0;
        end else begin
            frameValid <= lastShift;
            if (loadFire) begin
                state <= SHIFT;
                shiftReg <= loadData;
                lsbLatched <= lsbFirst;
            end else if (abortFire) begin
                state <= IDLE;
            end else if (shiftFire) begin
                shiftReg <= lsbLatched ? {serialDataIn, shiftReg[WIDTH-1:1]} : {shiftReg[WIDTH-2:0], serialDataIn};
                if (lastShift) state <= IDLE;
            end
        end
endmodule
